// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU sequencer: opcodes, ALU
// select codes, SKIP condition codes and the controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_BACK  = 4'h8;
  localparam logic [3:0] OP_SKIP  = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_CLEAR = 4'hB;
  localparam logic [3:0] OP_RSV_C = 4'hC;
  localparam logic [3:0] OP_RSV_D = 4'hD;
  localparam logic [3:0] OP_RSV_E = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD_IR, INCR, EX_ADDR, EX_READ, EX_ALU, EX_WB, ST_WR, CTRL, HALT
  } state_t;

  function automatic logic [3:0] alu_sel_for(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_next_pc.sv
// Combinational next-PC: sequential increment during INCR, and BACK / SKIP /
// JUMP targets during CTRL. Other opcodes leave the PC unchanged.
module cpu_next_pc
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [DATA_WIDTH-1:0] ac,
  input  logic                  incr,
  output logic [DATA_WIDTH-1:0] next_pc
);

  logic [DATA_WIDTH-1:0] offset;
  logic                  ac_neg;
  logic                  ac_zero;
  logic                  skip_taken;

  assign offset  = DATA_WIDTH'(ir[11:0]);
  assign ac_neg  = ac[DATA_WIDTH-1];
  assign ac_zero = (ac == '0);

  always_comb begin
    skip_taken = 1'b0;
    case (ir[11:10])
      SKIP_NEG:   skip_taken = ac_neg;
      SKIP_ZERO:  skip_taken = ac_zero;
      SKIP_POS:   skip_taken = !ac_neg && !ac_zero;
      SKIP_NEVER: skip_taken = 1'b0;
      default:    skip_taken = 1'b0;
    endcase
  end

  // BACK is relative to the already-incremented PC and wraps modulo 2^DATA_WIDTH
  always_comb begin
    next_pc = pc;
    if (incr) begin
      next_pc = pc + DATA_WIDTH'(1);
    end else begin
      case (ir[15:12])
        OP_BACK: next_pc = pc - offset;
        OP_SKIP: next_pc = skip_taken ? pc + DATA_WIDTH'(1) : pc;
        OP_JUMP: next_pc = offset;
        default: next_pc = pc;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator CPU; owns PC, IR,
// MAR, MBR, AC. Optional CPU_PERF_CNT_EN adds instr_retired/cycle_count.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]           instr_retired,
  output logic [31:0]           cycle_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] RESET_PC_W = DATA_WIDTH'(RESET_PC);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] ir_reg, ir_next;
  logic [DATA_WIDTH-1:0] mbr_reg, mbr_next;
  logic [DATA_WIDTH-1:0] ac_reg, ac_next;
  logic [ADDR_WIDTH-1:0] mar_reg, mar_next;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic [DATA_WIDTH-1:0] branch_pc;

  assign opcode  = ir_reg[15:12];
  assign ir_addr = ADDR_WIDTH'(ir_reg[11:0]);
  assign pc_addr = pc_reg[ADDR_WIDTH-1:0];

  cpu_next_pc #(.DATA_WIDTH(DATA_WIDTH)) u_next_pc (
    .pc      (pc_reg),
    .ir      (ir_reg),
    .ac      (ac_reg),
    .incr    (state_reg == INCR),
    .next_pc (branch_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC_W;
      ir_reg    <= '0;
      mar_reg   <= '0;
      mbr_reg   <= '0;
      ac_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      mar_reg   <= mar_next;
      mbr_reg   <= mbr_next;
      ac_reg    <= ac_next;
    end
  end

  // Memory strobes and ALU operands are decoded from registered state only, so
  // an async reset drops mem_we in the same instant rst_n falls.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    mar_next   = mar_reg;
    mbr_next   = mbr_reg;
    ac_next    = ac_reg;
    mem_addr   = mar_reg;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    mem_wdata  = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = ALU_NONE;
    illegal_op = 1'b0;

    case (state_reg)
      IDLE, HALT: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = RESET_PC_W;
        end
      end
      FETCH: begin
        mar_next   = pc_addr;
        mem_addr   = pc_addr;
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        state_next = LOAD_IR;
      end
      LOAD_IR: begin
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        ir_next    = mem_rdata;
        state_next = INCR;
      end
      INCR: begin
        pc_next = branch_pc;
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT:
            state_next = EX_ADDR;
          OP_BACK, OP_SKIP, OP_JUMP, OP_CLEAR:
            state_next = CTRL;
          OP_HALT:
            state_next = HALT;
          OP_NOP, OP_RSV_C, OP_RSV_D, OP_RSV_E: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      EX_ADDR: begin
        mar_next = ir_addr;
        mem_addr = ir_addr;
        if (opcode == OP_STORE) begin
          state_next = ST_WR;
        end else begin
          mem_cs     = 1'b1;
          mem_oe     = 1'b1;
          state_next = EX_READ;
        end
      end
      EX_READ: begin
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        mbr_next   = mem_rdata;
        state_next = (opcode == OP_LOAD) ? EX_WB : EX_ALU;
      end
      EX_ALU: begin
        alu_a      = ac_reg;
        alu_b      = mbr_reg;
        alu_sel    = alu_sel_for(opcode);
        state_next = EX_WB;
      end
      EX_WB: begin
        // Operands stay on the ALU through write-back so alu_out is still valid
        if (opcode == OP_LOAD) begin
          ac_next = mbr_reg;
        end else begin
          alu_a   = ac_reg;
          alu_b   = mbr_reg;
          alu_sel = alu_sel_for(opcode);
          ac_next = alu_out;
        end
        state_next = FETCH;
      end
      ST_WR: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_wdata  = ac_reg;
        state_next = FETCH;
      end
      CTRL: begin
        pc_next = branch_pc;
        if (opcode == OP_CLEAR) ac_next = '0;
        state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = !(state_reg inside {IDLE, HALT});
  assign halted = (state_reg == HALT);
  assign pc_out = pc_reg;
  assign ac_out = ac_reg;

`ifdef CPU_PERF_CNT_EN
  logic start_accept;
  logic retire;

  assign start_accept = start && (state_reg inside {IDLE, HALT});
  assign retire = ((state_next == FETCH) && (state_reg inside {INCR, EX_WB, ST_WR, CTRL}))
               || ((state_reg == INCR) && (state_next == HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      cycle_count   <= '0;
    end else if (start_accept) begin
      instr_retired <= '0;
      cycle_count   <= '0;
    end else begin
      if (retire && !(&instr_retired)) instr_retired <= instr_retired + 32'd1;
      if (busy && !(&cycle_count))     cycle_count   <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Synthesizable fetch/decode/execute controller for the 16-bit accumulator CPU. It owns PC, IR, MAR, MBR and AC, drives the single-port synchronous RAM (cs/we/oe) and the combinational ALU (A, B, ALU_Sel). It sits between the RAM and ALU instances in the CPU top and replaces bench-driven sequencing.

Parameters:
ADDR_WIDTH, 15, RAM address width; IR[11:0] is zero-extended to this width.
DATA_WIDTH, 16, word width of RAM, AC, MBR, IR and ALU operands.
RESET_PC, 'h100, PC value loaded at reset and on every start.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution from RESET_PC
busy  out  1  high in any state other than IDLE and HALT
halted  out  1  high in HALT
illegal_op  out  1  one-cycle pulse on an undefined opcode
mem_addr  out  ADDR_WIDTH  RAM address (MAR)
mem_cs  out  1  RAM chip select
mem_we  out  1  RAM write enable
mem_oe  out  1  RAM output enable (read)
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after read address
alu_a  out  DATA_WIDTH  ALU operand A (AC)
alu_b  out  DATA_WIDTH  ALU operand B (MBR)
alu_sel  out  4  ALU operation select
alu_out  in  DATA_WIDTH  ALU result, combinational
pc_out  out  DATA_WIDTH  current PC
ac_out  out  DATA_WIDTH  current AC

Behaviour:
- Reset (async, any state, including mid-instruction): state IDLE, PC=RESET_PC, IR/MAR/MBR/AC=0, alu_a/alu_b/alu_sel=0, all mem_* and status outputs 0. No RAM write may be issued after rst_n falls.
- States: IDLE, FETCH, LOAD_IR, INCR, EX_ADDR, EX_READ, EX_ALU, EX_WB, ST_WR, CTRL, HALT.
- IDLE: start -> FETCH, PC=RESET_PC. start is ignored while busy.
- FETCH: MAR=PC; cs=1, oe=1, we=0. LOAD_IR: IR=mem_rdata. INCR: PC=PC+1 (mod 2^DATA_WIDTH), then decode on IR[15:12].
- 1 LOAD: EX_ADDR (MAR=IR[11:0], read) -> EX_READ (MBR=rdata) -> EX_WB (AC=MBR). Total 6 cycles.
- 2 STORE: EX_ADDR (MAR=IR[11:0], cs=0) -> ST_WR (cs=1, we=1, oe=0, wdata=AC, exactly 1 cycle). Total 5 cycles.
- 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT: EX_ADDR -> EX_READ -> EX_ALU (alu_a=AC, alu_b=MBR, alu_sel=1,2,3,4,5 respectively) -> EX_WB (AC=alu_out). Total 7 cycles. NOT still reads memory; the result is ~AC.
- 8 BACK: CTRL, PC=PC-IR[11:0] (PC already incremented; modular wrap).
- 9 SKIP: CTRL. cond=IR[11:10]: 00 AC<0 (signed), 01 AC==0, 10 AC>0 (signed), 11 never. If cond holds, PC=PC+1.
- A JUMP: CTRL, PC=IR[11:0] zero-extended. B CLEAR: CTRL, AC=0. All CTRL ops take 4 cycles total.
- F HALT: -> HALT. halted=1, mem_cs=0. In HALT, start -> FETCH with PC=RESET_PC; AC is preserved.
- Opcodes 0, C, D, E: treated as NOP. illegal_op pulses during INCR, then -> FETCH.
- After EX_WB, ST_WR or CTRL -> FETCH.
- mem_cs=0 in IDLE, INCR, EX_ALU, EX_WB, CTRL and HALT. mem_we=1 only in ST_WR.
- AC, MBR and ALU operands wrap modulo 2^DATA_WIDTH; no flags are produced.

Optional Feature:
CPU_PERF_CNT_EN: when defined, adds outputs instr_retired[31:0] and cycle_count[31:0]. instr_retired increments on each transition into FETCH from an execute state or HALT entry. cycle_count increments while busy. Both clear on reset and on start and saturate at all-ones. When undefined, neither port nor counter exists.

Decomposition:
- Package cpu_pkg: opcode constants (OP_LOAD..OP_HALT), ALU_Sel codes (ALU_ADD=1, SUB=2, AND=3, OR=4, NOT=5), the state enum, and skip condition codes.
- Sub-module cpu_next_pc: combinational next-PC for INCR, BACK, SKIP and JUMP, taking PC, IR and AC.

Test Plan:
- Reset, then start, with 0x100=0x110C, 0x10C=0x0007, 0x101=0xF000 -> AC=7 after 6 cycles; halted=1; pc_out=0x102.
- LOAD 0x10B (5), ADD 0x10C (7), STORE 0x10D, HALT -> RAM[0x10D]=0x000C; exactly one we pulse; ADD phase alu_sel=1.
- AC=0xFFFF, SKIP 0x9000 -> PC advances by 2; AC=0, SKIP 0x9800 -> no skip; SKIP 0x9400 with AC=0 -> skip.
- JUMP 0xA120 -> next FETCH mem_addr=0x120; BACK 0x8003 at 0x130 -> next FETCH at 0x12E.
- Opcode 0xC000 -> illegal_op high for exactly 1 cycle, AC unchanged, next FETCH at PC+1.
- rst_n low during ST_WR -> mem_we=0 immediately; all outputs at reset values; start resumes at 0x100.
